seq_divider_32bit: RTL and testbench

- Multi-cycle radix-2 restoring integer divider producing quotient and remainder together.
- Serves RISC-V DIV/DIVU/REM/REMU as a lower-area alternative to the single-cycle combinational divider inside the ALU.
- Driven by a start/busy/done handshake from the datapath control, which stalls the pipeline while busy is high.
- Results follow RISC-V M-extension semantics, including divide-by-zero and signed overflow.

---
 rtl/seq_divider_32bit_if.sv | 24 ++
 rtl/seq_divider_32bit.sv | 111 +++++++++++
 tb/tb_seq_divider_32bit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_32bit_if.sv
// Start/busy/done handshake and operand/result bundle between datapath control and the divider.
interface seq_divider_32bit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             signed_op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor, signed_op,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor, signed_op,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_32bit.sv
// Radix-2 restoring divider with RISC-V M-extension result rules; fixed WIDTH+1 cycle latency.
module seq_divider_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_divider_32bit_if.slave div_if
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] dividend_q;
    logic             sign_q;
    logic             sign_r;
    logic             dz;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        sa      = div_if.signed_op & div_if.dividend[WIDTH-1];
        sb      = div_if.signed_op & div_if.divisor[WIDTH-1];
        a_mag   = sa ? (~div_if.dividend + 1'b1) : div_if.dividend;
        b_mag   = sb ? (~div_if.divisor + 1'b1) : div_if.divisor;
        shifted = {rem_q, quo_q[WIDTH-1]};
        // Extra guard bit so the sign of the trial is a clean borrow even when shifted[WIDTH] is set.
        trial   = {1'b0, shifted} - {2'b00, div_mag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            rem_q              <= '0;
            quo_q              <= '0;
            div_mag            <= '0;
            dividend_q         <= '0;
            sign_q             <= 1'b0;
            sign_r             <= 1'b0;
            dz                 <= 1'b0;
            ovf                <= 1'b0;
            cnt                <= '0;
            div_if.busy        <= 1'b0;
            div_if.done        <= 1'b0;
            div_if.quotient    <= '0;
            div_if.remainder   <= '0;
            div_if.div_by_zero <= 1'b0;
        end else begin
            div_if.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_if.start) begin
                        quo_q       <= a_mag;
                        div_mag     <= b_mag;
                        dividend_q  <= div_if.dividend;
                        sign_q      <= sa ^ sb;
                        sign_r      <= sa;
                        dz          <= (div_if.divisor == '0);
                        ovf         <= div_if.signed_op && (div_if.dividend == MIN_NEG)
                                       && (div_if.divisor == '1);
                        rem_q       <= '0;
                        cnt         <= '0;
                        div_if.busy <= 1'b1;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH+1]) begin
                        rem_q <= trial[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        div_if.quotient  <= '1;
                        div_if.remainder <= dividend_q;
                    end else if (ovf) begin
                        div_if.quotient  <= MIN_NEG;
                        div_if.remainder <= '0;
                    end else begin
                        div_if.quotient  <= sign_q ? (~quo_q + 1'b1) : quo_q;
                        div_if.remainder <= sign_r ? (~rem_q + 1'b1) : rem_q;
                    end
                    div_if.div_by_zero <= dz;
                    div_if.done        <= 1'b1;
                    div_if.busy        <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_32bit.sv
// Directed bench for seq_divider_32bit: results, latency, handshake and asynchronous reset.
module tb_seq_divider_32bit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_divider_32bit_if #(.WIDTH(32)) dif ();

    seq_divider_32bit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one start, then returns at #1 after the edge where done is seen (or after 40 edges).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output int busy_cnt, output int overlap,
                          output logic [31:0] q, output logic [31:0] r, output logic z);
        @(negedge clk);
        dif.dividend = a; dif.divisor = b; dif.signed_op = s; dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        lat = -1; overlap = 0;
        busy_cnt = dif.busy ? 1 : 0;
        q = 'x; r = 'x; z = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (dif.done && dif.busy) overlap++;
            if (dif.done) begin
                lat = n; q = dif.quotient; r = dif.remainder; z = dif.div_by_zero;
                break;
            end
            if (dif.busy) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0; dif.signed_op = 1'b0;
        #3;
        checks++;
        if ({dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero} !== 67'd0) begin
            errors++; $display("FAIL reset_outputs got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                               dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({dif.busy, dif.done} !== 2'b00) begin
            errors++; $display("FAIL reset_idle got busy=%b done=%b want 0 0", dif.busy, dif.done);
        end
    endtask

    task automatic test_unsigned;
        int lat, bc, ov; logic [31:0] q, r; logic z;
        run_op(32'd100, 32'd7, 1'b0, lat, bc, ov, q, r, z);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL unsigned_latency got %0d want 33", lat); end
        checks++;
        if (bc !== 33) begin errors++; $display("FAIL unsigned_busy_cycles got %0d want 33", bc); end
        checks++;
        if (ov !== 0) begin errors++; $display("FAIL busy_done_overlap got %0d want 0", ov); end
        checks++;
        if ({q, r, z} !== {32'd14, 32'd2, 1'b0}) begin
            errors++; $display("FAIL unsigned_100_7 got q=%h r=%h dz=%b want q=0000000e r=00000002 dz=0", q, r, z);
        end
        @(posedge clk); #1;
        checks++;
        if (dif.done !== 1'b0) begin errors++; $display("FAIL done_single_pulse got %b want 0", dif.done); end
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({dif.quotient, dif.remainder} !== {32'd14, 32'd2}) begin
            errors++; $display("FAIL hold_idle got q=%h r=%h want 0000000e 00000002", dif.quotient, dif.remainder);
        end
        run_op(32'hFFFFFFFF, 32'h80000001, 1'b0, lat, bc, ov, q, r, z);
        checks++;
        if ({q, r} !== {32'd1, 32'h7FFFFFFE}) begin
            errors++; $display("FAIL unsigned_large got q=%h r=%h want 00000001 7ffffffe", q, r);
        end
    endtask

    task automatic test_signed;
        int lat, bc, ov; logic [31:0] q, r; logic z;
        run_op(32'hFFFFFF9C, 32'd7, 1'b1, lat, bc, ov, q, r, z);
        checks++;
        if ({q, r} !== {32'hFFFFFFF2, 32'hFFFFFFFE}) begin
            errors++; $display("FAIL signed_neg_dividend got q=%h r=%h want fffffff2 fffffffe", q, r);
        end
        run_op(32'd100, 32'hFFFFFFF9, 1'b1, lat, bc, ov, q, r, z);
        checks++;
        if ({q, r} !== {32'hFFFFFFF2, 32'd2}) begin
            errors++; $display("FAIL signed_neg_divisor got q=%h r=%h want fffffff2 00000002", q, r);
        end
        run_op(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, lat, bc, ov, q, r, z);
        checks++;
        if ({q, r} !== {32'd3, 32'hFFFFFFFF}) begin
            errors++; $display("FAIL signed_both_neg got q=%h r=%h want 00000003 ffffffff", q, r);
        end
        run_op(32'h80000000, 32'd2, 1'b1, lat, bc, ov, q, r, z);
        checks++;
        if ({q, r} !== {32'hC0000000, 32'd0}) begin
            errors++; $display("FAIL signed_min_by_2 got q=%h r=%h want c0000000 00000000", q, r);
        end
    endtask

    task automatic test_div_by_zero;
        int lat, bc, ov; logic [31:0] q, r; logic z;
        for (int s = 0; s < 2; s++) begin
            run_op(32'h12345678, 32'd0, s[0], lat, bc, ov, q, r, z);
            checks++;
            if ({q, r, z} !== {32'hFFFFFFFF, 32'h12345678, 1'b1}) begin
                errors++; $display("FAIL dz_result s=%0d got q=%h r=%h dz=%b want ffffffff 12345678 1", s, q, r, z);
            end
            checks++;
            if (lat !== 33) begin errors++; $display("FAIL dz_latency s=%0d got %0d want 33", s, lat); end
        end
    endtask

    task automatic test_overflow;
        int lat, bc, ov; logic [31:0] q, r; logic z;
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bc, ov, q, r, z);
        checks++;
        if ({q, r, z} !== {32'h80000000, 32'd0, 1'b0}) begin
            errors++; $display("FAIL ovf_signed got q=%h r=%h dz=%b want 80000000 00000000 0", q, r, z);
        end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL ovf_latency got %0d want 33", lat); end
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bc, ov, q, r, z);
        checks++;
        if ({q, r} !== {32'd0, 32'h80000000}) begin
            errors++; $display("FAIL ovf_operands_unsigned got q=%h r=%h want 00000000 80000000", q, r);
        end
    endtask

    task automatic test_handshake;
        int lat;
        @(negedge clk);
        dif.dividend = 32'd1000; dif.divisor = 32'd3; dif.signed_op = 1'b0; dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 5 || n == 20) begin
                dif.dividend = 32'd77; dif.divisor = 32'd2; dif.signed_op = 1'b1; dif.start = 1'b1;
            end else begin
                dif.start = 1'b0;
            end
            if (dif.done) begin lat = n; break; end
        end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL ignored_start_latency got %0d want 33", lat); end
        checks++;
        if ({dif.quotient, dif.remainder} !== {32'd333, 32'd1}) begin
            errors++; $display("FAIL ignored_start_result got q=%h r=%h want 0000014d 00000001",
                               dif.quotient, dif.remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc, ov; logic [31:0] q, r; logic z;
        run_op(32'd1000, 32'd3, 1'b0, lat, bc, ov, q, r, z);
        // run_op returns inside the done cycle, so this start lands on the done cycle.
        run_op(32'd50, 32'd7, 1'b0, lat, bc, ov, q, r, z);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL back_to_back_latency got %0d want 33", lat); end
        checks++;
        if ({q, r} !== {32'd7, 32'd1}) begin
            errors++; $display("FAIL back_to_back_result got q=%h r=%h want 00000007 00000001", q, r);
        end
    endtask

    task automatic test_reset_midop;
        int lat, bc, ov, spurious; logic [31:0] q, r; logic z;
        @(negedge clk);
        dif.dividend = 32'd1000; dif.divisor = 32'd3; dif.signed_op = 1'b0; dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero} !== 67'd0) begin
            errors++; $display("FAIL midop_reset got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                               dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero);
        end
        @(negedge clk); rst_n = 1'b1;
        spurious = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (dif.done || dif.busy) spurious++;
        end
        checks++;
        if (spurious !== 0) begin errors++; $display("FAIL midop_spurious got %0d want 0", spurious); end
        run_op(32'd50, 32'd5, 1'b0, lat, bc, ov, q, r, z);
        checks++;
        if ({lat, q, r} !== {32'sd33, 32'd10, 32'd0}) begin
            errors++; $display("FAIL after_reset_50_5 got lat=%0d q=%h r=%h want 33 0000000a 00000000", lat, q, r);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_handshake();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
